// File: rtl/msg_seq_tx.sv
// Message sequencer: streams a stored message from a synchronous message memory
// into an AXI-stream byte sink, with table/terminator length, repeat with gap, and abort.
module msg_seq_tx #(
  parameter int                    N_BITS     = 8,
  parameter int                    MEM_DEPTH  = 64,
  parameter int                    N_MSGS     = 4,
  parameter logic [16*N_MSGS-1:0]  MSG_BASE   = '0,
  parameter logic [16*N_MSGS-1:0]  MSG_LEN    = '0,
  parameter int                    TERM_MODE  = 0,
  parameter logic [N_BITS-1:0]     TERM_CHAR  = '0,
  parameter int unsigned           GAP_CYCLES = 1000,
  localparam int                   AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int                   SW = (N_MSGS > 1) ? $clog2(N_MSGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SW-1:0]     msg_sel,
  input  logic              repeat_en,
  input  logic              abort,
  output logic [AW-1:0]     mem_addr,
  input  logic [N_BITS-1:0] mem_data,
  output logic [N_BITS-1:0] axis_tdata,
  output logic              axis_tvalid,
  input  logic              axis_tready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sent_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND, S_END, S_GAP} state_t;

  state_t            state, state_n;
  logic              start_q;
  logic              start_edge;
  logic [AW-1:0]     base_l, base_n;
  logic [15:0]       len_l, len_n;
  logic [31:0]       gap_cnt, gap_n;
  logic              abort_pend, pend_n;
  logic [AW-1:0]     addr_n, addr_inc;
  logic [N_BITS-1:0] tdata_n;
  logic              tvalid_n;
  logic [15:0]       cnt_n, cnt_inc;
  logic              done_n;
  logic              decide;
  logic              last;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_n  = state;
    addr_n   = mem_addr;
    tdata_n  = axis_tdata;
    tvalid_n = axis_tvalid;
    cnt_n    = sent_cnt;
    done_n   = 1'b0;
    base_n   = base_l;
    len_n    = len_l;
    gap_n    = gap_cnt;
    pend_n   = 1'b0;
    decide   = 1'b0;
    last     = 1'b0;
    cnt_inc  = sent_cnt + 16'd1;
    addr_inc = (mem_addr == AW'(MEM_DEPTH - 1)) ? '0 : mem_addr + AW'(1);

    case (state)
      S_IDLE: begin
        if (start_edge && !abort) begin
          base_n = '0;
          len_n  = '0;
          for (int unsigned k = 0; k < N_MSGS; k++) begin
            if (msg_sel == SW'(k)) begin
              base_n = AW'(MSG_BASE[16*k +: 16]);
              len_n  = MSG_LEN[16*k +: 16];
            end
          end
          addr_n = base_n;
          cnt_n  = '0;
          if (TERM_MODE == 0 && len_n == '0) done_n = 1'b1;
          else                               state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (TERM_MODE != 0 && mem_data == TERM_CHAR) begin
          state_n = S_END;
        end else begin
          tdata_n  = mem_data;
          tvalid_n = 1'b1;
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        // An abort seen while the word is held is remembered until its handshake.
        pend_n = abort_pend | abort;
        if (axis_tready) begin
          tvalid_n = 1'b0;
          cnt_n    = cnt_inc;
          last     = (TERM_MODE == 0) ? (cnt_inc == len_l) : (cnt_inc == 16'hFFFF);
          if (pend_n) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            pend_n  = 1'b0;
          end else if (last) begin
            state_n = S_END;
          end else begin
            addr_n  = addr_inc;
            state_n = S_FETCH;
          end
        end
      end
      S_END: begin
        if (abort) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          gap_n   = GAP_CYCLES - 32'd1;
          state_n = S_GAP;
        end else begin
          decide = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (gap_cnt == '0) begin
          decide = 1'b1;
        end else begin
          gap_n = gap_cnt - 32'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (decide) begin
      if (repeat_en) begin
        addr_n  = base_l;
        cnt_n   = '0;
        state_n = S_FETCH;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      base_l      <= '0;
      len_l       <= '0;
      gap_cnt     <= '0;
      abort_pend  <= 1'b0;
      mem_addr    <= '0;
      axis_tdata  <= '0;
      axis_tvalid <= 1'b0;
      sent_cnt    <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      start_q     <= start;
      base_l      <= base_n;
      len_l       <= len_n;
      gap_cnt     <= gap_n;
      abort_pend  <= pend_n;
      mem_addr    <= addr_n;
      axis_tdata  <= tdata_n;
      axis_tvalid <= tvalid_n;
      sent_cnt    <= cnt_n;
      done        <= done_n;
      busy        <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_msg_seq_tx.sv
// Bench for msg_seq_tx: table-mode instance (gap 5) and terminator-mode instance (gap 0)
// sharing one byte memory; expectations come from message tables and memory contents.
module tb_msg_seq_tx;

  localparam int DEPTH = 64;
  localparam int GAP_A = 5;
  // message k at bits [16k+15:16k]; k: 0..7
  localparam logic [127:0] BASE_A = {16'd55, 16'd50, 16'd44, 16'd40, 16'd30, 16'd62, 16'd10, 16'd0};
  localparam logic [127:0] LEN_A  = {16'd6,  16'd1,  16'd5,  16'd2,  16'd0,  16'd4,  16'd3,  16'd4};
  localparam logic [63:0]  BASE_B = {16'd23, 16'd20, 16'd25, 16'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, rep_a, abort_a, tready_a, tvalid_a, busy_a, done_a;
  logic [2:0]  sel_a;
  logic [5:0]  addr_a;
  logic [7:0]  mdata_a, tdata_a;
  logic [15:0] cnt_a;
  logic        start_b, rep_b, abort_b, tready_b, tvalid_b, busy_b, done_b;
  logic [1:0]  sel_b;
  logic [5:0]  addr_b;
  logic [7:0]  mdata_b, tdata_b;
  logic [15:0] cnt_b;

  logic [7:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [5:0] got_ad[$];
  int         got_edge[$];
  int         first_valid, done_cnt, done_edge, stab_err, late_valid;
  logic       busy_c0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) mdata_a <= mem[addr_a];
  always_ff @(posedge clk) mdata_b <= mem[addr_b];

  msg_seq_tx #(
    .N_BITS(8), .MEM_DEPTH(DEPTH), .N_MSGS(8), .MSG_BASE(BASE_A), .MSG_LEN(LEN_A),
    .TERM_MODE(0), .TERM_CHAR(8'h00), .GAP_CYCLES(GAP_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .msg_sel(sel_a), .repeat_en(rep_a),
    .abort(abort_a), .mem_addr(addr_a), .mem_data(mdata_a), .axis_tdata(tdata_a),
    .axis_tvalid(tvalid_a), .axis_tready(tready_a), .busy(busy_a), .done(done_a),
    .sent_cnt(cnt_a)
  );

  msg_seq_tx #(
    .N_BITS(8), .MEM_DEPTH(DEPTH), .N_MSGS(4), .MSG_BASE(BASE_B), .MSG_LEN(64'd0),
    .TERM_MODE(1), .TERM_CHAR(8'h00), .GAP_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .msg_sel(sel_b), .repeat_en(rep_b),
    .abort(abort_b), .mem_addr(addr_b), .mem_data(mdata_b), .axis_tdata(tdata_b),
    .axis_tvalid(tvalid_b), .axis_tready(tready_b), .busy(busy_b), .done(done_b),
    .sent_cnt(cnt_b)
  );

  function automatic int base_a(input int k);
    return int'(BASE_A[16*k +: 16]);
  endfunction

  function automatic int len_a(input int k);
    return int'(LEN_A[16*k +: 16]);
  endfunction

  // Edge 0 is the edge that samples the start edge; negedge c follows edge c.
  task automatic run_a(input int sel, input int ready_pct, input int stop_hs, input int max_cyc);
    bit         held;
    logic [7:0] hdata;
    int         tail;
    got_q.delete(); got_ad.delete(); got_edge.delete();
    first_valid = -1; done_cnt = 0; done_edge = -1; stab_err = 0; late_valid = 0;
    held = 1'b0; hdata = '0; tail = 0; busy_c0 = 1'b0;
    @(negedge clk);
    sel_a = 3'(sel); start_a = 1'b1; rep_a = (stop_hs > 0); tready_a = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start_a = 1'b0;
        busy_c0 = busy_a;
      end
      if (held && (!tvalid_a || tdata_a !== hdata)) stab_err++;
      if (tvalid_a && first_valid < 0) first_valid = c;
      if (done_cnt > 0 && tvalid_a) late_valid++;
      if (done_a) begin
        done_cnt++;
        if (done_edge < 0) done_edge = c;
      end
      tready_a = (int'($urandom_range(99)) < ready_pct);
      held  = tvalid_a && !tready_a;
      hdata = tdata_a;
      if (tvalid_a && tready_a) begin
        got_q.push_back(tdata_a);
        got_ad.push_back(addr_a);
        got_edge.push_back(c + 1);
        if (stop_hs > 0 && got_q.size() >= stop_hs) rep_a = 1'b0;
      end
      if (done_cnt > 0) begin
        tail++;
        if (tail > 6) break;
      end
    end
    tready_a = 1'b0;
    rep_a    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tvalid_a !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a); end
    checks++; if (addr_a !== 6'd0 || tdata_a !== 8'd0) begin
      errors++; $display("FAIL reset_addr_data: got addr %0d data %0h expected 0 0", addr_a, tdata_a);
    end
    checks++; if (tvalid_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL reset_b: got tvalid %b busy %b expected 0 0", tvalid_b, busy_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bad;
    run_a(0, 100, 0, 60);
    checks++; if (first_valid != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", first_valid); end
    checks++; if (busy_c0 !== 1'b1) begin errors++; $display("FAIL basic_busy_high: got %b expected 1", busy_c0); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_hs_count: got %0d expected 4", got_q.size()); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 4; i++)
      if (got_q[i] !== 8'(65 + i) || got_edge[i] != 3 + 3*i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_bytes: got %0d bad bytes expected 0", bad); end
    checks++; if (done_cnt != 1 || done_edge != 3*4 + 1 + GAP_A) begin
      errors++; $display("FAIL basic_done: got cnt %0d edge %0d expected 1 %0d", done_cnt, done_edge, 3*4 + 1 + GAP_A);
    end
    checks++; if (busy_a !== 1'b0 || late_valid != 0) begin
      errors++; $display("FAIL basic_idle_after: got busy %b late %0d expected 0 0", busy_a, late_valid);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_a(1, 20, 0, 400);
    bad = (got_q.size() != 3) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < 3; i++) if (got_q[i] !== mem[10 + i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_bytes: got %0d bad (n=%0d) expected 0", bad, got_q.size()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_err); end
    checks++; if (cnt_a !== 16'd3 || done_cnt != 1) begin
      errors++; $display("FAIL bp_cnt_done: got cnt %0d done %0d expected 3 1", cnt_a, done_cnt);
    end
  endtask

  task automatic test_wrap();
    int bad;
    int exp_ad[4] = '{62, 63, 0, 1};
    run_a(2, 100, 0, 60);
    bad = (got_q.size() != 4) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < 4; i++)
      if (int'(got_ad[i]) != exp_ad[i] || got_q[i] !== mem[exp_ad[i]]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_addr: got %0d bad (n=%0d) expected 0", bad, got_q.size()); end
  endtask

  task automatic test_len_zero();
    run_a(3, 100, 0, 20);
    checks++; if (done_cnt != 1 || done_edge != 0) begin
      errors++; $display("FAIL len0_done: got cnt %0d edge %0d expected 1 0", done_cnt, done_edge);
    end
    checks++; if (first_valid != -1 || busy_c0 !== 1'b0) begin
      errors++; $display("FAIL len0_quiet: got first_valid %0d busy %b expected -1 0", first_valid, busy_c0);
    end
  endtask

  task automatic test_random_msgs();
    int sels[7] = '{0, 1, 2, 4, 5, 6, 7};
    for (int it = 0; it < 5; it++) begin
      int sel, b, l, pct, bad;
      sel = sels[$urandom_range(6)];
      b   = base_a(sel);
      l   = len_a(sel);
      pct = int'($urandom_range(25, 100));
      run_a(sel, pct, 0, 400);
      bad = (got_q.size() != l) ? 1 : 0;
      for (int i = 0; i < got_q.size() && i < l; i++)
        if (got_q[i] !== mem[(b + i) % DEPTH] || int'(got_ad[i]) != (b + i) % DEPTH) bad++;
      checks++; if (bad != 0) begin
        errors++; $display("FAIL random_seq sel %0d: got %0d bad (n=%0d) expected 0 (len %0d)", sel, bad, got_q.size(), l);
      end
      checks++; if (done_cnt != 1 || stab_err != 0 || late_valid != 0 || cnt_a !== 16'(l)) begin
        errors++; $display("FAIL random_ctrl sel %0d: got done %0d stab %0d late %0d cnt %0d expected 1 0 0 %0d",
                           sel, done_cnt, stab_err, late_valid, cnt_a, l);
      end
    end
  endtask

  task automatic test_repeat();
    int l, nrep, bad, period, last;
    l      = len_a(4);
    nrep   = int'($urandom_range(2, 3));
    period = 3*l + 1 + GAP_A;
    run_a(4, 100, (nrep - 1)*l + 1, 300);
    bad = (got_q.size() != nrep*l) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < nrep*l; i++)
      if (got_q[i] !== mem[base_a(4) + i % l] || got_edge[i] != 3 + (i / l)*period + 3*(i % l)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL repeat_pattern: got %0d bad (n=%0d) expected 0 (reps %0d)", bad, got_q.size(), nrep); end
    last = 3 + (nrep - 1)*period + 3*(l - 1);
    checks++; if (done_cnt != 1 || done_edge != last + 1 + GAP_A) begin
      errors++; $display("FAIL repeat_done: got cnt %0d edge %0d expected 1 %0d", done_cnt, done_edge, last + 1 + GAP_A);
    end
  endtask

  task automatic test_abort();
    int guard, hold, held_bad, late;
    @(negedge clk);
    sel_a = 3'd5; start_a = 1'b1; tready_a = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      guard++;
    end while (!tvalid_a && guard < 20);
    abort_a  = 1'b1;
    hold     = int'($urandom_range(2, 5));
    held_bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (tvalid_a !== 1'b1 || tdata_a !== mem[44]) held_bad++;
    end
    checks++; if (held_bad != 0 || guard >= 20) begin
      errors++; $display("FAIL abort_hold: got %0d drops (guard %0d) expected 0", held_bad, guard);
    end
    tready_a = 1'b1;
    @(negedge clk);
    tready_a = 1'b0;
    abort_a  = 1'b0;
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0 || tvalid_a !== 1'b0 || cnt_a !== 16'd1) begin
      errors++; $display("FAIL abort_send_end: got done %b busy %b tvalid %b cnt %0d expected 1 0 0 1", done_a, busy_a, tvalid_a, cnt_a);
    end
    late = 0;
    repeat (8) begin
      @(negedge clk);
      if (tvalid_a || done_a) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", late); end

    @(negedge clk);
    sel_a = 3'd0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL abort_fetch: got done %b busy %b expected 1 0", done_a, busy_a);
    end
    late = 0;
    repeat (6) begin
      @(negedge clk);
      if (tvalid_a) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL abort_fetch_quiet: got %0d tvalid cycles expected 0", late); end

    @(negedge clk);
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL abort_over_start: got busy %b done %b expected 0 0", busy_a, done_a);
    end
  endtask

  task automatic test_reset_mid();
    int guard, bad;
    @(negedge clk);
    sel_a = 3'd7; start_a = 1'b1; tready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    guard = 0;
    while (cnt_a < 16'd2 && guard < 50) begin @(negedge clk); guard++; end
    tready_a = 1'b0;
    while (!tvalid_a && guard < 100) begin @(negedge clk); guard++; end
    checks++; if (tvalid_a !== 1'b1) begin errors++; $display("FAIL midreset_setup: got tvalid %b expected 1", tvalid_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tvalid_a !== 1'b0 || busy_a !== 1'b0 || addr_a !== 6'd0 || cnt_a !== 16'd0 || tdata_a !== 8'd0) begin
      errors++; $display("FAIL midreset_outputs: got tvalid %b busy %b addr %0d cnt %0d data %0h expected all 0",
                         tvalid_a, busy_a, addr_a, cnt_a, tdata_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_a(0, 100, 0, 60);
    bad = (got_q.size() != 4) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < 4; i++) if (got_q[i] !== 8'(65 + i)) bad++;
    checks++; if (bad != 0 || done_cnt != 1) begin
      errors++; $display("FAIL midreset_restart: got %0d bad done %0d expected 0 1", bad, done_cnt);
    end
  endtask

  task automatic test_term_mode();
    int sels[3] = '{2, 1, 3};
    for (int n = 0; n < 3; n++) begin
      logic [7:0] exp_q[$];
      logic [7:0] q[$];
      int b, dcnt, late, tail, bad;
      b = int'(BASE_B[16*sels[n] +: 16]);
      exp_q.delete();
      q.delete();
      for (int i = 0; i < DEPTH && mem[(b + i) % DEPTH] != 8'h00; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
      dcnt = 0; late = 0; tail = 0;
      @(negedge clk);
      sel_b = 2'(sels[n]); start_b = 1'b1; tready_b = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (n != 0) start_b = 1'b0;
        if (dcnt > 0 && tvalid_b) late++;
        if (done_b) dcnt++;
        tready_b = ($urandom_range(1) == 1);
        if (tvalid_b && tready_b) q.push_back(tdata_b);
        if (dcnt > 0) begin
          tail++;
          if (tail > 6) break;
        end
      end
      start_b = 1'b0; tready_b = 1'b0;
      bad = (q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < q.size() && i < exp_q.size(); i++) if (q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin
        errors++; $display("FAIL term_bytes sel %0d: got %0d bad (n=%0d) expected 0 (n=%0d)", sels[n], bad, q.size(), exp_q.size());
      end
      checks++; if (dcnt != 1 || late != 0 || busy_b !== 1'b0 || cnt_b !== 16'(exp_q.size())) begin
        errors++; $display("FAIL term_ctrl sel %0d: got done %0d late %0d busy %b cnt %0d expected 1 0 0 %0d",
                           sels[n], dcnt, late, busy_b, cnt_b, exp_q.size());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; rep_a = 1'b0; abort_a = 1'b0; tready_a = 1'b0; sel_a = '0;
    start_b = 1'b0; rep_b = 1'b0; abort_b = 1'b0; tready_b = 1'b0; sel_b = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 4; i++) mem[i] = 8'(65 + i);
    mem[20] = 8'h48; mem[21] = 8'h49; mem[22] = 8'h21; mem[23] = 8'h00;
    mem[27] = 8'h00;

    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_random_msgs();
    test_repeat();
    test_abort();
    test_reset_mid();
    test_term_mode();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion within time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
